// File: rtl/hazard_pkg.sv
// Shared opcode map, forwarding-select codes and scoreboard stage records for the
// 5-stage core's hazard controller.
package hazard_pkg;

    localparam int REGW = 4;
    localparam int OPW  = 4;

    // 1110 is unassigned; it uses no sources and never branches.
    typedef enum logic [OPW-1:0] {
        OP_NOP    = 4'b0000,
        OP_MOVI   = 4'b0001,
        OP_STB    = 4'b0010,
        OP_MOV    = 4'b0011,
        OP_OUT    = 4'b0100,
        OP_ADD    = 4'b0101,
        OP_SUB    = 4'b0110,
        OP_LDB    = 4'b0111,
        OP_OR     = 4'b1000,
        OP_SHIFTL = 4'b1001,
        OP_CMP    = 4'b1010,
        OP_BEQ    = 4'b1011,
        OP_BR     = 4'b1100,
        OP_BLT    = 4'b1101,
        OP_JMP    = 4'b1111
    } opcode_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_WB = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef struct packed {
        logic            valid;
        logic [OPW-1:0]  op;
        logic [REGW-1:0] src_a;
        logic [REGW-1:0] src_b;
        logic [REGW-1:0] dst;
        logic            we;
        logic            is_load;
    } e_stage_t;

    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] dst;
        logic            we;
    } mw_stage_t;

    function automatic logic usesSrcA(input logic [OPW-1:0] op);
        logic r;
        case (op)
            OP_STB, OP_MOV, OP_OUT, OP_ADD, OP_SUB, OP_LDB,
            OP_OR, OP_SHIFTL, OP_CMP, OP_BR: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic usesSrcB(input logic [OPW-1:0] op);
        logic r;
        case (op)
            OP_STB, OP_ADD, OP_SUB, OP_OR, OP_SHIFTL, OP_CMP: r = 1'b1;
            default:                                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/forward_select.sv
// Operand forwarding select for one E-stage source: M result beats WB result,
// and an empty E slot never forwards.
module forward_select
    import hazard_pkg::*;
(
    input  logic            e_valid_i,
    input  logic [REGW-1:0] src_i,
    input  logic            m_valid_i,
    input  logic            m_we_i,
    input  logic [REGW-1:0] m_dst_i,
    input  logic            wb_valid_i,
    input  logic            wb_we_i,
    input  logic [REGW-1:0] wb_dst_i,
    output logic [1:0]      sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (e_valid_i) begin
            if (m_valid_i && m_we_i && (m_dst_i == src_i)) begin
                sel_o = FWD_M;
            end else if (wb_valid_i && wb_we_i && (wb_dst_i == src_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing: E/M/WB destination scoreboard, load-use stall, branch
// resolution in E with F/D + D/E flush, operand forwarding and the CMP flag register.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int ADDRESSWIDTH = 4,
    parameter int OPCODEWIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODEWIDTH-1:0]  opcodeD,
    input  logic [ADDRESSWIDTH-1:0] srcAD,
    input  logic [ADDRESSWIDTH-1:0] srcBD,
    input  logic [ADDRESSWIDTH-1:0] dstD,
    input  logic                    writeEnableDD,
    input  logic                    resultSelectorWBD,
    input  logic                    zeroE,
    input  logic                    negativeE,
    output logic                    stallF,
    output logic                    stallD,
    output logic                    flushD,
    output logic                    flushE,
    output logic [1:0]              forwardAE,
    output logic [1:0]              forwardBE,
    output logic                    pcSrcE,
    output logic                    flagZ,
    output logic                    flagN
);

    e_stage_t  e_q, e_d;
    mw_stage_t m_q, m_d, wb_q, wb_d;
    logic      flag_z_q, flag_z_d, flag_n_q, flag_n_d;
    logic      take_branch, load_use, stall, flush_e;

    logic [1:0][REGW-1:0] e_src;
    logic [1:0][1:0]      fwd_sel;

    assign e_src[0] = e_q.src_a;
    assign e_src[1] = e_q.src_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            forward_select u_fwd (
                .e_valid_i  (e_q.valid),
                .src_i      (e_src[gi]),
                .m_valid_i  (m_q.valid),
                .m_we_i     (m_q.we),
                .m_dst_i    (m_q.dst),
                .wb_valid_i (wb_q.valid),
                .wb_we_i    (wb_q.we),
                .wb_dst_i   (wb_q.dst),
                .sel_o      (fwd_sel[gi])
            );
        end
    endgenerate

    always_comb begin
        take_branch = 1'b0;
        if (e_q.valid) begin
            case (e_q.op)
                OP_JMP, OP_BR: take_branch = 1'b1;
                OP_BEQ:        take_branch = flag_z_q;
                OP_BLT:        take_branch = flag_n_q;
                default:       take_branch = 1'b0;
            endcase
        end
    end

    assign load_use = e_q.valid && e_q.is_load && e_q.we &&
                      ((usesSrcA(opcodeD) && (srcAD == e_q.dst)) ||
                       (usesSrcB(opcodeD) && (srcBD == e_q.dst)));

    // A taken branch discards the dependent instruction, so it cancels the stall.
    assign stall   = load_use && !take_branch;
    assign flush_e = load_use || take_branch;

    always_comb begin
        e_d = '0;
        if (!flush_e) begin
            e_d.valid   = 1'b1;
            e_d.op      = opcodeD;
            e_d.src_a   = srcAD;
            e_d.src_b   = srcBD;
            e_d.dst     = dstD;
            e_d.we      = writeEnableDD && (opcodeD != OP_NOP);
            e_d.is_load = resultSelectorWBD;
        end
        m_d.valid = e_q.valid;
        m_d.dst   = e_q.dst;
        m_d.we    = e_q.we;
        wb_d      = m_q;
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
        if (e_q.valid && (e_q.op == OP_CMP)) begin
            flag_z_d = zeroE;
            flag_n_d = negativeE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q      <= '0;
            m_q      <= '0;
            wb_q     <= '0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            e_q      <= e_d;
            m_q      <= m_d;
            wb_q     <= wb_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
        end
    end

    assign stallF    = !reset && stall;
    assign stallD    = !reset && stall;
    assign flushD    = !reset && take_branch;
    assign flushE    = !reset && flush_e;
    assign pcSrcE    = !reset && take_branch;
    assign forwardAE = reset ? FWD_RF : fwd_sel[0];
    assign forwardBE = reset ? FWD_RF : fwd_sel[1];
    assign flagZ     = !reset && flag_z_q;
    assign flagN     = !reset && flag_n_q;

endmodule
